// File: rtl/mdu_rv32.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps plus one fix-up cycle.
// Every operation takes the same number of cycles, so the pipeline can stall on busy alone.
module mdu_rv32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] da,
  input  logic [XLEN-1:0] db,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand signedness: MULH/MULHSU treat rs1 as signed, MULH/DIV/REM both.
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] abs_a, abs_b;

  assign sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
  assign sgn_b = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
  assign neg_a = sgn_a && da[XLEN-1];
  assign neg_b = sgn_b && db[XLEN-1];
  assign abs_a = neg_a ? -da : da;
  assign abs_b = neg_b ? -db : db;

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_next = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};

  // Divide step: dividend shifts out of prod_q[XLEN-1:0] while quotient bits shift in.
  logic [XLEN+1:0]   rem_sh, rem_diff;
  logic              q_bit;
  logic [XLEN:0]     rem_next;
  logic [2*XLEN-1:0] div_next;

  assign rem_sh   = {rem_q, prod_q[XLEN-1]};
  assign rem_diff = rem_sh - {2'b00, b_q};
  assign q_bit    = ~rem_diff[XLEN+1];
  assign rem_next = q_bit ? rem_diff[XLEN:0] : rem_sh[XLEN:0];
  assign div_next = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], q_bit};

  // Final sign fix-up and corner values.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_val;
  logic              b_zero;

  assign prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
  assign quo      = prod_q[XLEN-1:0];
  assign rem      = rem_q[XLEN-1:0];
  assign b_zero   = (b_q == '0);

  always_comb begin
    fix_val = '0;
    case (op_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = b_zero ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
      // With a zero divisor the remainder register ends up holding |da|, so restoring da's sign yields da.
      default:                fix_val = sa_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d = RUN;
          op_d    = funct3;
          sa_d    = neg_a;
          sb_d    = neg_b;
          b_d     = abs_b;
          prod_d  = {{XLEN{1'b0}}, abs_a};
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          prod_d = op_q[2] ? div_next : mul_next;
          rem_d  = op_q[2] ? rem_next : rem_q;
          if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          result_d = fix_val;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_rv32.sv
// Randomised and directed bench for mdu_rv32 against a 64-bit arithmetic reference model.
module tb_mdu_rv32;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] da, db;
  logic        busy, done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_rv32 dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .da(da), .db(db), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    r  = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, scramble operands after the start edge, then check latency, pulse width and value.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int nb, it;
    logic [31:0] exp;
    exp = ref_model(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; da = a; db = b;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); da = $urandom; db = $urandom;
    nb = 0; it = 0;
    while (!done && it < 100) begin
      if (busy) nb++;
      it++;
      @(negedge clk);
    end
    check({tag, "/busy_cycles"}, 32'(nb), 32'd33);
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "/result"}, result, exp);
    @(negedge clk);
    check({tag, "/done_width"}, 32'(done), 32'd0);
  endtask

  task automatic watch_no_done(input string tag, input logic [31:0] held);
    int nd;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check({tag, "/no_done"}, 32'(nd), 32'd0);
    check({tag, "/result_held"}, result, held);
  endtask

  initial begin
    int d1, d2, nd, it;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; da = '0; db = '0;
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    do_op(3'd5, 32'd100, 32'd7, "divu");
    do_op(3'd7, 32'd100, 32'd7, "remu");
    do_op(3'd4, 32'd5, 32'd0, "div_by0");
    do_op(3'd7, 32'd5, 32'd0, "remu_by0");
    do_op(3'd6, 32'hFFFF_FFF0, 32'd0, "rem_by0_neg");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Kill in the 10th RUN cycle of a divide.
    do_op(3'd5, 32'd100, 32'd7, "pre_kill");
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; da = 32'd1000; db = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_run/busy", 32'(busy), 32'd0);
    watch_no_done("kill_run", 32'd14);

    // Kill while in the fix-up cycle.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; da = 32'd9; db = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("kill_fix/busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_fix/busy", 32'(busy), 32'd0);
    watch_no_done("kill_fix", 32'd14);

    // Asynchronous reset in the middle of a multiply.
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "pre_rst");
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; da = 32'd123; db = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid/busy", 32'(busy), 32'd0);
    check("rst_mid/done", 32'(done), 32'd0);
    check("rst_mid/result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'd0, 32'd123, 32'd456, "post_rst");

    // start held high: one acceptance per IDLE visit, 35-cycle issue interval.
    a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd3; da = a; db = b;
    d1 = -1; d2 = -1; nd = 0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = i; else d2 = i;
        check("held/result", result, ref_model(3'd3, a, b));
      end
    end
    check("held/done_count", 32'(nd), 32'd2);
    check("held/first_done", 32'(d1), 32'd33);
    check("held/interval", 32'(d2 - d1), 32'd35);
    start = 1'b0;
    it = 0;
    while (!done && it < 60) begin
      it++;
      @(negedge clk);
    end
    check("held/drain", 32'(done), 32'd1);
    @(negedge clk);

    // start and kill together in IDLE.
    start = 1'b1; kill = 1'b1;
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) nd++;
    end
    check("start_kill/busy_cycles", 32'(nd), 32'd0);
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("start_kill/busy_after", 32'(busy), 32'd0);

    for (int i = 0; i < 150; i++) begin
      do_op(3'($urandom), pick(), pick(), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
